// File: rtl/ballot_unit.sv
// ballot_unit: synchronised, debounced three-button voter front end with a one-vote-per-ballot FSM.
// Optional ARMED-state timeout is built only when BALLOT_TIMEOUT_EN is defined.
module ballot_unit #(
    parameter int DB_CYCLES = 1000,
    parameter int DB_W      = 10,
    parameter int PULSE_LEN = 4
`ifdef BALLOT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ballot_en,
    input  logic        i_btn1,
    input  logic        i_btn2,
    input  logic        i_btn3,
    input  logic        i_voting_over,
    output logic        o_candidate_1,
    output logic        o_candidate_2,
    output logic        o_candidate_3,
    output logic        o_ready,
    output logic        o_reject,
    output logic        o_timeout,
    output logic [15:0] o_votes_cast
);

    // state   | meaning
    // LOCKED  | no ballot issued, presses ignored
    // ARMED   | ballot issued, waiting for a single clean press
    // CAST    | driving the vote pulse for the latched candidate
    // RELEASE | waiting for every button to be let go
    typedef enum logic [1:0] {LOCKED, ARMED, CAST, RELEASE} state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam int              PC_W    = $clog2(PULSE_LEN + 1);
    localparam logic [PC_W-1:0] PC_END  = PC_W'(PULSE_LEN);

    state_t          state, state_nxt;
    logic [2:0]      btn_raw, sync1, sync2, lvl, lvl_q, press, cand;
    logic [DB_W-1:0] db_cnt [3];
    logic [PC_W-1:0] pulse_cnt;
    logic            multi, accept, pulse_done, pulse_on;
    logic            reject_nxt, reject_q, tmo_hit;
    logic [15:0]     votes;

    assign btn_raw = {i_btn3, i_btn2, i_btn1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            lvl_q <= lvl;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    lvl[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press = lvl & ~lvl_q;
    assign multi = (lvl[0] & lvl[1]) | (lvl[0] & lvl[2]) | (lvl[1] & lvl[2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOCKED;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        reject_nxt = 1'b0;
        pulse_done = 1'b0;
        case (state)
            LOCKED: begin
                if (i_ballot_en && !i_voting_over) state_nxt = ARMED;
            end
            ARMED: begin
                if (i_voting_over) begin
                    state_nxt = LOCKED;
                end else if ((|press) && !multi) begin
                    accept    = 1'b1;
                    state_nxt = CAST;
                end else begin
                    reject_nxt = |press;
                    if (tmo_hit) state_nxt = LOCKED;
                end
            end
            CAST: begin
                if (pulse_cnt == PC_END) begin
                    pulse_done = 1'b1;
                    state_nxt  = RELEASE;
                end
            end
            RELEASE: begin
                if (lvl == 3'b000) state_nxt = LOCKED;
            end
            default: state_nxt = LOCKED;
        endcase
    end

    // Pulse runs off its own counter so a mid-pulse poll end cannot truncate it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand      <= '0;
            pulse_cnt <= '0;
            pulse_on  <= 1'b0;
            votes     <= '0;
            reject_q  <= 1'b0;
        end else begin
            reject_q <= reject_nxt;
            if (accept) begin
                cand      <= lvl;
                pulse_cnt <= '0;
            end
            if (state == CAST && !pulse_done) begin
                pulse_cnt <= pulse_cnt + PC_W'(1);
                pulse_on  <= 1'b1;
            end else begin
                pulse_on  <= 1'b0;
            end
            if (pulse_done && votes != 16'hFFFF) votes <= votes + 16'd1;
        end
    end

`ifdef BALLOT_TIMEOUT_EN
    localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TM_W-1:0] tmo_cnt;
    logic            timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ARMED && state_nxt == ARMED) tmo_cnt <= tmo_cnt + TM_W'(1);
            else                                      tmo_cnt <= '0;
            // ARMED -> LOCKED without a poll end can only be an expiry.
            timeout_q <= (state == ARMED) && (state_nxt == LOCKED) && !i_voting_over;
        end
    end

    assign tmo_hit   = (tmo_cnt == TM_W'(TIMEOUT_CYCLES - 1));
    assign o_timeout = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_candidate_1 = pulse_on & cand[0];
    assign o_candidate_2 = pulse_on & cand[1];
    assign o_candidate_3 = pulse_on & cand[2];
    assign o_ready       = (state == ARMED);
    assign o_reject      = reject_q;
    assign o_votes_cast  = votes;

endmodule

// File: tb/tb_ballot_unit.sv
// Bench for ballot_unit: directed scenarios plus random stimulus, checked every cycle
// against a behavioural model of the ballot rules (sliding-window debounce, event schedule).
module tb_ballot_unit;
    localparam int DB = 8;
    localparam int PL = 4;
`ifdef BALLOT_TIMEOUT_EN
    localparam int TMO = 50;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ballot_en = 1'b0, btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0, voting_over = 1'b0;
    logic        c1, c2, c3, ready, reject, timeout;
    logic [15:0] votes;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int pulses [3] = '{0, 0, 0};
    bit prev_c [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    ballot_unit #(
        .DB_CYCLES(DB),
        .DB_W(4),
        .PULSE_LEN(PL)
`ifdef BALLOT_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_ballot_en(ballot_en),
        .i_btn1(btn1),
        .i_btn2(btn2),
        .i_btn3(btn3),
        .i_voting_over(voting_over),
        .o_candidate_1(c1),
        .o_candidate_2(c2),
        .o_candidate_3(c3),
        .o_ready(ready),
        .o_reject(reject),
        .o_timeout(timeout),
        .o_votes_cast(votes)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 locked, 1 armed, 2 casting, 3 releasing
    int phase, edge_n, accept_edge, armed_cycles, cand_idx, exp_votes;
    bit lvl [3], rose [3], exp_c [3];
    bit hist [3][0:DB+1];
    bit exp_ready, exp_reject, exp_timeout;

    always @(posedge clk or negedge rst) begin
        bit raw [3];
        bit nl, all_diff, any_rose;
        int nh, d;
        if (!rst) begin
            phase = 0; edge_n = 0; accept_edge = 0; armed_cycles = 0; cand_idx = 0;
            exp_votes = 0; exp_ready = 0; exp_reject = 0; exp_timeout = 0;
            for (int i = 0; i < 3; i++) begin
                lvl[i] = 0; rose[i] = 0; exp_c[i] = 0;
                for (int j = 0; j <= DB + 1; j++) hist[i][j] = 0;
            end
        end else begin
            raw[0] = btn1; raw[1] = btn2; raw[2] = btn3;
            edge_n++;
            for (int i = 0; i < 3; i++) begin
                for (int j = DB + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = raw[i];
            end
            nh = 0; any_rose = 0;
            for (int i = 0; i < 3; i++) begin
                nh += int'(lvl[i]);
                if (rose[i]) any_rose = 1;
            end
            exp_reject = 0; exp_timeout = 0;
            for (int i = 0; i < 3; i++) exp_c[i] = 0;
            case (phase)
                0: if (ballot_en && !voting_over) begin phase = 1; armed_cycles = 0; end
                1: begin
                    if (voting_over) phase = 0;
                    else if (any_rose && nh == 1) begin
                        phase = 2; accept_edge = edge_n;
                        for (int i = 0; i < 3; i++) if (lvl[i]) cand_idx = i;
                    end else begin
                        if (any_rose) exp_reject = 1;
`ifdef BALLOT_TIMEOUT_EN
                        armed_cycles++;
                        if (armed_cycles == TMO) begin exp_timeout = 1; phase = 0; end
`endif
                    end
                end
                2: begin
                    d = edge_n - accept_edge;
                    if (d <= PL) exp_c[cand_idx] = 1;
                    else begin
                        if (exp_votes < 65535) exp_votes++;
                        phase = 3;
                    end
                end
                default: if (nh == 0) phase = 0;
            endcase
            // a level flips once the synced input has disagreed with it for DB straight samples
            for (int i = 0; i < 3; i++) begin
                all_diff = 1;
                for (int j = 2; j <= DB + 1; j++) if (hist[i][j] == lvl[i]) all_diff = 0;
                nl = all_diff ? !lvl[i] : lvl[i];
                rose[i] = nl && !lvl[i];
                lvl[i] = nl;
            end
            exp_ready = (phase == 1);
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst === 1'b1 && chk_en) begin
            check("cand1", c1, exp_c[0]);
            check("cand2", c2, exp_c[1]);
            check("cand3", c3, exp_c[2]);
            check("ready", ready, exp_ready);
            check("reject", reject, exp_reject);
            check("timeout", timeout, exp_timeout);
            check("votes", votes, exp_votes);
            check("onehot", int'((int'(c1) + int'(c2) + int'(c3)) <= 1), 1);
        end
    end

    always @(negedge clk) begin
        bit cur [3];
        cur[0] = c1; cur[1] = c2; cur[2] = c3;
        for (int i = 0; i < 3; i++) begin
            if (cur[i] && !prev_c[i]) pulses[i]++;
            prev_c[i] = cur[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ballot_pulse();
        @(negedge clk); ballot_en = 1'b1;
        @(negedge clk); ballot_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, p2, rcount, seen;
        // reset then idle
        tick(3);
        #1;
        check("rst_cand", int'(c1 | c2 | c3), 0);
        check("rst_votes", votes, 0);
        @(negedge clk); rst = 1'b1; chk_en = 1'b1;
        tick(1); #1;
        check("idle_ready", ready, 0);
        check("idle_votes", votes, 0);
        check("idle_reject", reject, 0);

        // single vote with 12-cycle latency
        @(negedge clk); ballot_en = 1'b1; btn2 = 1'b1;
        tick(1); ballot_en = 1'b0; #1;
        check("sv_ready_on", ready, 1);
        tick(10); #1; check("sv_pre_pulse", c2, 0);
        tick(1);  #1; check("sv_pulse_start", c2, 1); check("sv_ready_off", ready, 0);
        tick(3);  #1; check("sv_pulse_last", c2, 1);
        tick(1);  #1; check("sv_pulse_end", c2, 0); check("sv_votes", votes, 1);
        tick(14); btn2 = 1'b0;
        tick(20);

        // bounce then hold
        p0 = pulses[0];
        @(negedge clk); ballot_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            btn1 = ((k / 3) % 2 == 0);
            tick(1); ballot_en = 1'b0;
        end
        check("bnc_no_pulse", pulses[0] - p0, 0);
        btn1 = 1'b1;
        tick(40); #1;
        check("bnc_one_pulse", pulses[0] - p0, 1);
        check("bnc_votes", votes, 2);
        ballot_pulse(); #1;
        check("bnc_held_no_arm", ready, 0);
        tick(20); #1;
        check("bnc_held_votes", votes, 2);
        btn1 = 1'b0;
        tick(15);
        ballot_pulse(); #1;
        check("rearm_ready", ready, 1);

        // poll end while armed
        @(negedge clk); voting_over = 1'b1;
        tick(1); #1; check("over_ready", ready, 0);
        btn3 = 1'b1;
        tick(20); #1;
        check("over_votes", votes, 2);
        btn3 = 1'b0; voting_over = 1'b0;
        tick(15);

        // unarmed press
        p2 = pulses[2];
        @(negedge clk); btn3 = 1'b1;
        tick(20); #1;
        check("unarmed_votes", votes, 2);
        check("unarmed_pulse", pulses[2] - p2, 0);
        btn3 = 1'b0;
        tick(15);

        // multi-press: first event wins
        p0 = pulses[0]; p2 = pulses[2];
        @(negedge clk); ballot_en = 1'b1; btn1 = 1'b1;
        tick(1); ballot_en = 1'b0;
        tick(3); btn3 = 1'b1;
        tick(30); #1;
        check("mp1_c1", pulses[0] - p0, 1);
        check("mp1_c3", pulses[2] - p2, 0);
        check("mp1_votes", votes, 3);
        btn1 = 1'b0; btn3 = 1'b0;
        tick(20);

        // multi-press: armed with two held, third added -> reject
        p0 = pulses[0]; p1 = pulses[1]; p2 = pulses[2];
        @(negedge clk); btn1 = 1'b1; btn3 = 1'b1;
        tick(15);
        ballot_pulse();
        tick(3); btn2 = 1'b1;
        rcount = 0;
        for (int k = 0; k < 25; k++) begin
            tick(1); #1;
            if (reject) rcount++;
        end
        check("mp2_reject_cycles", rcount, 1);
        check("mp2_pulses", (pulses[0] - p0) + (pulses[1] - p1) + (pulses[2] - p2), 0);
        check("mp2_votes", votes, 3);
        btn1 = 1'b0; btn2 = 1'b0; btn3 = 1'b0;
        @(negedge clk); voting_over = 1'b1;
        @(negedge clk); voting_over = 1'b0;
        tick(20);

`ifdef BALLOT_TIMEOUT_EN
        @(negedge clk); ballot_en = 1'b1;
        tick(1); ballot_en = 1'b0; #1;
        check("tmo_armed", ready, 1);
        tick(48); #1;
        check("tmo_pre_ready", ready, 1);
        check("tmo_pre_pulse", timeout, 0);
        tick(1); #1;
        check("tmo_ready", ready, 0);
        check("tmo_pulse", timeout, 1);
        tick(1); #1;
        check("tmo_pulse_1cyc", timeout, 0);
        check("tmo_votes", votes, 3);
        tick(5);
`endif

        // reset in the middle of a pulse
        @(negedge clk); ballot_en = 1'b1; btn1 = 1'b1;
        tick(1); ballot_en = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick(1); #1;
            if (c1) seen = 1;
        end
        check("mid_cast_seen", seen, 1);
        @(negedge clk); rst = 1'b0; #1;
        check("mid_cast_drop", c1, 0);
        check("mid_cast_votes", votes, 0);
        tick(2); rst = 1'b1; btn1 = 1'b0;
        tick(20);

        // random traffic
        for (int it = 0; it < 300; it++) begin
            int pat, hold;
            pat  = $urandom_range(0, 9);
            hold = $urandom_range(1, 25);
            @(negedge clk);
            if (pat < 3) begin
                btn1 = (pat == 0); btn2 = (pat == 1); btn3 = (pat == 2);
            end else if (pat < 6) begin
                btn1 = 1'b0; btn2 = 1'b0; btn3 = 1'b0;
            end else begin
                btn1 = 1'($urandom_range(0, 1));
                btn2 = 1'($urandom_range(0, 1));
                btn3 = 1'($urandom_range(0, 1));
            end
            ballot_en   = ($urandom_range(0, 2) == 0);
            voting_over = ($urandom_range(0, 15) == 0);
            tick(1);
            ballot_en = 1'b0;
            if (hold > 1) tick(hold - 1);
        end
        btn1 = 1'b0; btn2 = 1'b0; btn3 = 1'b0; voting_over = 1'b0;
        tick(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
